// File: rtl/bcd_display_pkg.sv
// Shared definitions for the binary-to-BCD display converter.
//
// Contents:
//   CODE_OVF / CODE_ERR  reserved display words for out-of-range and error requests
//   MAX_VAL              largest magnitude (in thousandths) that fits six BCD digits
//   BLANK_NIBBLE         nibble value the display renders as an unlit digit
//   conv_state_t         converter FSM state encoding
//   blank_leading()      replaces leading zero hundreds/tens nibbles with BLANK_NIBBLE

package bcd_display_pkg;

   localparam logic [23:0] CODE_OVF     = 24'hFFFFFF;
   localparam logic [23:0] CODE_ERR     = 24'hFFFFFE;
   localparam int unsigned MAX_VAL      = 999999;
   localparam logic [3:0]  BLANK_NIBBLE = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      FIN  = 2'd2
   } conv_state_t;

   // Only the two integer-part digits above "ones" may be blanked, and tens
   // only when hundreds is also blank, so "0.250" stays readable as " 0.250".
   function automatic logic [23:0] blank_leading(input logic [23:0] w);
      logic [23:0] r;
      r = w;
      if (w[23:20] == 4'd0) begin
         r[23:20] = BLANK_NIBBLE;
         if (w[19:16] == 4'd0) begin
            r[19:16] = BLANK_NIBBLE;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or
// more so that the following left shift carries correctly into the next digit.
//
// Ports:
//   din   4-bit BCD digit before correction
//   dout  4-bit digit after correction

module bcd_add3_digit (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   always_comb begin
      dout = din;
      if (din >= 4'd5) begin
         dout = din + 4'd3;
      end
   end

endmodule

// File: rtl/bcd_display_converter.sv
// Sequential binary-to-BCD converter feeding the six-digit 7-segment display.
// Converts an unsigned magnitude in thousandths into six packed BCD nibbles
// {hundreds,tens,ones,tenths,hundredths,thousandths} using double-dabble,
// one bit per clock. Error and out-of-range requests bypass the conversion
// and produce the display's reserved codes.
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  blank leading zero hundreds/tens digits of numeric results
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   start     conversion request, honoured only when idle
//   value     unsigned magnitude in thousandths
//   neg       sign of the request, 1 = negative
//   err       show the error code instead of a value
//   busy      high while a conversion is in progress
//   done      one-cycle pulse; bcd/sign_out valid from this cycle on
//   bcd       packed BCD result, held until the next done
//   sign_out  sign latched with the request, held with bcd
//
// State | meaning
// IDLE  | waiting for start; a request latches inputs and performs the first shift
// CONV  | one double-dabble step per cycle until all IN_W bits are shifted in
// FIN   | publish result/sign, pulse done, return to IDLE
//
// The first double-dabble step is folded into the IDLE accept: the
// accumulator is zero there, so its add-3 stage is a no-op and only the shift
// remains. CONV then performs the remaining IN_W-1 steps, which gives a
// request-to-done latency of IN_W+1 cycles on the normal path and 2 cycles on
// the error/overflow path.

module bcd_display_converter
   import bcd_display_pkg::*;
#(
   parameter int IN_W   = 20,
   parameter int DIGITS = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [IN_W-1:0]       value,
   input  logic                  neg,
   input  logic                  err,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  sign_out
);

   localparam int ACC_W = 4*DIGITS;
   localparam int CNT_W = $clog2(IN_W + 1);

   conv_state_t          state;
   logic [ACC_W-1:0]     acc;
   logic [IN_W-1:0]      shreg;
   logic [CNT_W-1:0]     cnt;
   logic [ACC_W-1:0]     res;
   logic                 res_is_code;
   logic                 neg_q;

   logic [ACC_W-1:0]     acc_adj;
   logic [ACC_W+IN_W-1:0] shifted;
   logic [ACC_W-1:0]     acc_next;
   logic [IN_W-1:0]      shreg_next;
   logic [ACC_W-1:0]     digits_word;
   logic [ACC_W-1:0]     fin_word;
   logic                 over_range;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3_digit u_add3 (
         .din  (acc[4*g +: 4]),
         .dout (acc_adj[4*g +: 4])
      );
   end

   always_comb begin
      shifted    = {acc_adj, shreg} << 1;
      acc_next   = shifted[ACC_W+IN_W-1:IN_W];
      shreg_next = shifted[IN_W-1:0];
   end

   assign over_range = 32'(value) > MAX_VAL;

   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      digits_word = blank_leading(res);
`else
      digits_word = res;
`endif
      fin_word = res_is_code ? res : digits_word;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         acc         <= '0;
         shreg       <= '0;
         cnt         <= '0;
         res         <= '0;
         res_is_code <= 1'b0;
         neg_q       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         bcd         <= '0;
         sign_out    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  neg_q <= neg;
                  busy  <= 1'b1;
                  if (err) begin
                     res         <= CODE_ERR;
                     res_is_code <= 1'b1;
                     state       <= FIN;
                  end else if (over_range) begin
                     res         <= CODE_OVF;
                     res_is_code <= 1'b1;
                     state       <= FIN;
                  end else begin
                     {acc, shreg} <= {{(ACC_W-1){1'b0}}, value, 1'b0};
                     cnt          <= CNT_W'(IN_W - 1);
                     res_is_code  <= 1'b0;
                     state        <= CONV;
                  end
               end
            end
            CONV: begin
               acc   <= acc_next;
               shreg <= shreg_next;
               cnt   <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  res   <= acc_next;
                  state <= FIN;
               end
            end
            FIN: begin
               bcd      <= fin_word;
               sign_out <= neg_q;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_display_converter.sv
module tb_bcd_display_converter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [19:0] value = '0;
   logic        neg = 1'b0;
   logic        err = 1'b0;
   logic        busy;
   logic        done;
   logic [23:0] bcd;
   logic        sign_out;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state (outputs expected after each edge)
   logic        m_done = 1'b0;
   logic        m_busy = 1'b0;
   logic [23:0] m_bcd  = '0;
   logic        m_sign = 1'b0;
   int          m_pend = 0;
   logic [23:0] p_bcd  = '0;
   logic        p_sign = 1'b0;

   bcd_display_converter #(.IN_W(20), .DIGITS(6)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .value    (value),
      .neg      (neg),
      .err      (err),
      .busy     (busy),
      .done     (done),
      .bcd      (bcd),
      .sign_out (sign_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      n_assert++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
      end
   endtask

   // Expected display word computed from decimal arithmetic.
   function automatic logic [23:0] exp_word(input int unsigned v, input logic e);
      logic [23:0] w;
      int unsigned d[6];
      int unsigned t;
      if (e) return 24'hFFFFFE;
      if (v > 999999) return 24'hFFFFFF;
      t = v;
      w = '0;
      for (int i = 0; i < 6; i++) begin
         d[i] = t % 10;
         t = t / 10;
         w[4*i +: 4] = 4'(d[i]);
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (d[5] == 0) begin
         w[23:20] = 4'hF;
         if (d[4] == 0) w[19:16] = 4'hF;
      end
`endif
      return w;
   endfunction

   // Transaction-level model: a request is accepted when nothing is pending,
   // and its result appears after a fixed latency (2 for codes, 21 otherwise).
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_done <= 1'b0;
         m_busy <= 1'b0;
         m_bcd  <= '0;
         m_sign <= 1'b0;
         m_pend <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_pend > 0) begin
            m_pend <= m_pend - 1;
            if (m_pend == 1) begin
               m_done <= 1'b1;
               m_busy <= 1'b0;
               m_bcd  <= p_bcd;
               m_sign <= p_sign;
            end
         end else if (start) begin
            p_bcd  <= exp_word(32'(value), err);
            p_sign <= neg;
            m_pend <= (err || value > 20'd999999) ? 1 : 20;
            m_busy <= 1'b1;
         end
      end
   end

   bit cmp_en = 1'b0;
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_done", 32'(done), 32'(m_done));
         check("cyc_busy", 32'(busy), 32'(m_busy));
         check("cyc_bcd", 32'(bcd), 32'(m_bcd));
         check("cyc_sign", 32'(sign_out), 32'(m_sign));
      end
   end

   // Issue one request and measure cycles until done (cycle of start = 0).
   task automatic do_req(input string name, input logic [19:0] v, input logic n, input logic e,
                         input logic [23:0] eb, input logic es, input int elat);
      int lat;
      @(negedge clk);
      #1;
      start = 1'b1; value = v; neg = n; err = e;
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (done) break;
         #1 start = 1'b0;
      end
      start = 1'b0;
      check({name, "_lat"}, 32'(lat), 32'(elat));
      check({name, "_bcd"}, 32'(bcd), 32'(eb));
      check({name, "_sign"}, 32'(sign_out), 32'(es));
   endtask

   function automatic logic [23:0] lit(input logic [23:0] raw, input logic [23:0] blanked);
`ifdef LEADING_ZERO_BLANK_EN
      return blanked;
`else
      return raw;
`endif
   endfunction

   int ndone;

   initial begin
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_bcd", 32'(bcd), 32'h0);
      check("rst_sign", 32'(sign_out), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);

      // pin the model with hand-computed words
      check("model_7250", 32'(exp_word(7250, 1'b0)), 32'(lit(24'h007250, 24'hFF7250)));
      check("model_42000", 32'(exp_word(42000, 1'b0)), 32'(lit(24'h042000, 24'hF42000)));
      check("model_ovf", 32'(exp_word(1000000, 1'b0)), 32'hFFFFFF);

      do_req("v123456", 20'd123456, 1'b0, 1'b0, 24'h123456, 1'b0, 21);
      do_req("v999999", 20'd999999, 1'b0, 1'b0, 24'h999999, 1'b0, 21);
      do_req("v1000000", 20'd1000000, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 2);
      do_req("err", 20'd1000000, 1'b1, 1'b1, 24'hFFFFFE, 1'b1, 2);
      do_req("neg0", 20'd0, 1'b1, 1'b0, lit(24'h000000, 24'hFF0000), 1'b1, 21);
      do_req("v7250", 20'd7250, 1'b0, 1'b0, lit(24'h007250, 24'hFF7250), 1'b0, 21);
      do_req("v42000", 20'd42000, 1'b0, 1'b0, lit(24'h042000, 24'hF42000), 1'b0, 21);
      do_req("vmax20", 20'hFFFFF, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 2);

      // second start during CONV is ignored
      @(negedge clk);
      #1 start = 1'b1; value = 20'd123456; neg = 1'b0; err = 1'b0;
      @(negedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      #1 start = 1'b1; value = 20'd5;
      @(negedge clk);
      #1 start = 1'b0;
      ndone = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("ign_ndone", 32'(ndone), 32'd1);
      check("ign_bcd", 32'(bcd), 32'h123456);

      // reset mid-conversion
      @(negedge clk);
      #1 start = 1'b1; value = 20'd999999; neg = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      check("mrst_busy", 32'(busy), 32'h0);
      check("mrst_done", 32'(done), 32'h0);
      check("mrst_bcd", 32'(bcd), 32'h0);
      check("mrst_sign", 32'(sign_out), 32'h0);
      #1 reset = 1'b0;
      ndone = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("mrst_ndone", 32'(ndone), 32'd0);

      // randomized traffic, checked every cycle by the model
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         #1;
         start = ($urandom % 3) == 0;
         case ($urandom % 4)
            0: value = 20'($urandom_range(999990, 1000010));
            1: value = 20'($urandom);
            default: value = 20'($urandom_range(0, 999999));
         endcase
         neg = 1'($urandom);
         err = ($urandom % 8) == 0;
      end
      #1 start = 1'b0;
      repeat (30) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
